decoder_onehot_seq: RTL

//  Parametrised, registered N-to-2^N one-hot decoder for register-file write-enable generation.

---
 rtl/decoder_onehot_seq.sv | 91 +++++++++
 1 files changed

// File: rtl/decoder_onehot_seq.sv
// decoder_onehot_seq: registered N-to-2^N one-hot decoder with a self-test walk across every output.
// Optional DEC_ONEHOT_CHECK_EN adds a sticky onehot_err port.
module decoder_onehot_seq #(
    parameter int IN_W     = 5,
    parameter int SCAN_DIV = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 in_valid,
    input  logic [IN_W-1:0]      in,
    input  logic                 start_scan,
    output logic [2**IN_W-1:0]   out,
    output logic                 out_valid,
    output logic                 scan_busy,
    output logic                 scan_done
`ifdef DEC_ONEHOT_CHECK_EN
    ,
    output logic                 onehot_err
`endif
);
    localparam int OW = 2**IN_W;
    localparam int DW = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;
    localparam logic [DW-1:0] DWELL_MAX = DW'(SCAN_DIV);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]      state;
    logic [IN_W-1:0] idx;
    logic [DW-1:0]   dwell;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            dwell     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            scan_busy <= 1'b0;
            scan_done <= 1'b0;
        end else begin
            out       <= '0;
            out_valid <= 1'b0;
            scan_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (en && start_scan) begin
                        state     <= SCAN;
                        idx       <= '0;
                        dwell     <= '0;
                        out       <= OW'(1);
                        scan_busy <= 1'b1;
                    end else if (en && in_valid) begin
                        out       <= OW'(1) << in;
                        out_valid <= 1'b1;
                    end
                end
                // en=0 leaves idx/dwell untouched so the walk resumes where it paused
                SCAN: begin
                    if (en) begin
                        if (dwell == DWELL_MAX) begin
                            dwell <= '0;
                            if (&idx) begin
                                state     <= DONE;
                                scan_busy <= 1'b0;
                                scan_done <= 1'b1;
                            end else begin
                                idx <= idx + 1'b1;
                                out <= OW'(1) << (idx + 1'b1);
                            end
                        end else begin
                            dwell <= dwell + 1'b1;
                            out   <= OW'(1) << idx;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DEC_ONEHOT_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset)
            onehot_err <= 1'b0;
        else if (((out & (out - 1'b1)) != '0) || (out_valid && out == '0))
            onehot_err <= 1'b1;
    end
`endif
endmodule
